// File: rtl/pt_pkg.sv
// Shared types and constants for the pixel transform engine: state encoding,
// default frame geometry and the pipeline sizing helper.
package pt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } pt_state_t;

    localparam int          IMG_W_DEF    = 320;
    localparam int          IMG_H_DEF    = 240;
    localparam logic [11:0] BG_COLOR_DEF = 12'h000;
    localparam int          MAP_LAT_DEF  = 4;
    localparam int          RD_LAT_DEF   = 2;

    // The in-flight counter must hold every pixel between map_req and dst_we.
    function automatic int inflight_width(input int map_lat, input int rd_lat);
        return $clog2(map_lat + rd_lat + 3);
    endfunction

endpackage

// File: rtl/pt_delay_line.sv
// Fixed-depth shift register used to carry pixel side-band data
// (destination address, valid, in-range flag) alongside the external pipelines.
module pt_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [DEPTH];

    // NOTE: this array is cleared on reset because it carries valid bits;
    // a real storage memory would be left unreset so it can map onto RAM.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
            stage[0] <= d;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/pixel_transform_engine.sv
// Raster-scans the destination frame, sends coordinates to the homography mapper,
// fetches (or background-fills) each source pixel and writes the destination frame.
module pixel_transform_engine
    import pt_pkg::*;
#(
    parameter int               IMG_W    = IMG_W_DEF,
    parameter int               IMG_H    = IMG_H_DEF,
    parameter int               XW       = 9,
    parameter int               YW       = 8,
    parameter int               SW       = 11,
    parameter int               ADDR_W   = 17,
    parameter int               PIX_W    = 12,
    parameter int               MAP_LAT  = MAP_LAT_DEF,
    parameter int               RD_LAT   = RD_LAT_DEF,
    parameter logic [PIX_W-1:0] BG_COLOR = PIX_W'(BG_COLOR_DEF)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              hold,
    output logic              busy,
    output logic              done,
    output logic              map_req,
    output logic [XW-1:0]     map_x,
    output logic [YW-1:0]     map_y,
    input  logic              map_valid,
    input  logic [SW-1:0]     map_sx,
    input  logic [SW-1:0]     map_sy,
    output logic              src_rd_en,
    output logic [ADDR_W-1:0] src_rd_addr,
    input  logic [PIX_W-1:0]  src_rd_data,
    output logic              dst_we,
    output logic [ADDR_W-1:0] dst_addr,
    output logic [PIX_W-1:0]  dst_data
);

    localparam int IFW = inflight_width(MAP_LAT, RD_LAT);

    pt_state_t         state, state_nxt;
    logic              armed_q;
    logic [XW-1:0]     x_q;
    logic [YW-1:0]     y_q;
    logic [ADDR_W-1:0] lin_q, iss_addr;
    logic [IFW-1:0]    inflight_q, inflight_nxt;
    logic              issue, last_pix;

    logic              ret_valid, r_valid, w_valid, w_in_range;
    logic [ADDR_W-1:0] ret_addr, r_addr, w_addr, src_addr_full;
    logic              in_range;

    assign issue    = (state == ST_RUN) && !hold;
    assign last_pix = (x_q == XW'(IMG_W - 1)) && (y_q == YW'(IMG_H - 1));
    assign busy     = (state != ST_IDLE);
    assign done     = (state == ST_DONE);

    assign inflight_nxt = inflight_q + IFW'(map_req) - IFW'(dst_we);

    // armed_q keeps a start coinciding with reset release from launching a run.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            armed_q    <= 1'b0;
            inflight_q <= '0;
        end else begin
            state      <= state_nxt;
            armed_q    <= 1'b1;
            inflight_q <= inflight_nxt;
        end
    end

    // NOTE: state_nxt gets a default before the case so no path infers a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start && armed_q)      state_nxt = ST_RUN;
            ST_RUN:   if (issue && last_pix)     state_nxt = ST_DRAIN;
            ST_DRAIN: if (inflight_nxt == '0)    state_nxt = ST_DONE;
            ST_DONE:                             state_nxt = ST_IDLE;
            default:                             state_nxt = ST_IDLE;
        endcase
    end

    // Raster scan; the linear address tracks (x,y) without a multiplier.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_q      <= '0;
            y_q      <= '0;
            lin_q    <= '0;
            map_req  <= 1'b0;
            map_x    <= '0;
            map_y    <= '0;
            iss_addr <= '0;
        end else begin
            map_req <= issue;
            if (state == ST_IDLE) begin
                x_q   <= '0;
                y_q   <= '0;
                lin_q <= '0;
            end else if (issue) begin
                map_x    <= x_q;
                map_y    <= y_q;
                iss_addr <= lin_q;
                lin_q    <= lin_q + ADDR_W'(1);
                if (x_q == XW'(IMG_W - 1)) begin
                    x_q <= '0;
                    y_q <= y_q + YW'(1);
                end else begin
                    x_q <= x_q + XW'(1);
                end
            end
        end
    end

    pt_delay_line #(.WIDTH(ADDR_W + 1), .DEPTH(MAP_LAT)) u_map_dly (
        .clk     (clk),
        .reset_n (reset_n),
        .d       ({map_req, iss_addr}),
        .q       ({ret_valid, ret_addr})
    );

    assign in_range = !map_sx[SW-1] && ($signed(map_sx) < $signed(SW'(IMG_W))) &&
                      !map_sy[SW-1] && ($signed(map_sy) < $signed(SW'(IMG_H)));
    assign src_addr_full = ADDR_W'(map_sy) * ADDR_W'(IMG_W) + ADDR_W'(map_sx);

    // Return stage: the internal valid, not map_valid, qualifies the mapper result.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid     <= 1'b0;
            r_addr      <= '0;
            src_rd_en   <= 1'b0;
            src_rd_addr <= '0;
        end else begin
            r_valid     <= ret_valid;
            r_addr      <= ret_addr;
            src_rd_en   <= ret_valid && in_range;
            src_rd_addr <= (ret_valid && in_range) ? src_addr_full : '0;
        end
    end

    pt_delay_line #(.WIDTH(ADDR_W + 2), .DEPTH(RD_LAT)) u_rd_dly (
        .clk     (clk),
        .reset_n (reset_n),
        .d       ({r_valid, src_rd_en, r_addr}),
        .q       ({w_valid, w_in_range, w_addr})
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dst_we   <= 1'b0;
            dst_addr <= '0;
            dst_data <= '0;
        end else begin
            dst_we   <= w_valid;
            dst_addr <= w_addr;
            dst_data <= w_in_range ? src_rd_data : BG_COLOR;
        end
    end

    map_valid_a: assert property (@(posedge clk) disable iff (!reset_n) ret_valid |-> map_valid);

endmodule

// File: tb/tb_pixel_transform_engine.sv
// Scoreboard bench: a small 8x4 engine exercised with randomized mappings and
// control events, plus a full-size 320x240 engine run in parallel.
module tb_pixel_transform_engine;

    localparam int          W = 8, H = 4, N = W * H;
    localparam int          MAP_LAT = 4, RD_LAT = 2, LAT = MAP_LAT + RD_LAT + 2;
    localparam int          BW = 320, BH = 240, BN = BW * BH;
    localparam logic [11:0] BG = 12'hA5C;

    typedef struct { bit v; logic [10:0] sx; logic [10:0] sy; } map_ent_t;
    typedef struct { int addr; logic [11:0] data; } wexp_t;

    logic clk = 1'b0, reset_n, start, hold;
    logic busy, done, map_req, map_valid, src_rd_en, dst_we;
    logic [8:0]  map_x;
    logic [7:0]  map_y;
    logic [10:0] map_sx, map_sy;
    logic [16:0] src_rd_addr, dst_addr;
    logic [11:0] src_rd_data, dst_data;

    logic b_reset_n, b_start, b_hold;
    logic b_busy, b_done, b_map_req, b_map_valid, b_src_rd_en, b_dst_we;
    logic [8:0]  b_map_x;
    logic [7:0]  b_map_y;
    logic [10:0] b_map_sx, b_map_sy;
    logic [16:0] b_src_rd_addr, b_dst_addr;
    logic [11:0] b_src_rd_data, b_dst_data;

    always #5 clk = ~clk;

    pixel_transform_engine #(.IMG_W(W), .IMG_H(H), .BG_COLOR(BG)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .hold(hold), .busy(busy), .done(done),
        .map_req(map_req), .map_x(map_x), .map_y(map_y), .map_valid(map_valid),
        .map_sx(map_sx), .map_sy(map_sy), .src_rd_en(src_rd_en), .src_rd_addr(src_rd_addr),
        .src_rd_data(src_rd_data), .dst_we(dst_we), .dst_addr(dst_addr), .dst_data(dst_data)
    );

    pixel_transform_engine big (
        .clk(clk), .reset_n(b_reset_n), .start(b_start), .hold(b_hold), .busy(b_busy),
        .done(b_done), .map_req(b_map_req), .map_x(b_map_x), .map_y(b_map_y),
        .map_valid(b_map_valid), .map_sx(b_map_sx), .map_sy(b_map_sy),
        .src_rd_en(b_src_rd_en), .src_rd_addr(b_src_rd_addr), .src_rd_data(b_src_rd_data),
        .dst_we(b_dst_we), .dst_addr(b_dst_addr), .dst_data(b_dst_data)
    );

    int n_checks = 0, n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // ---------------- small engine: reference model and scoreboard ----------------
    logic [11:0] src_mem [N];
    map_ent_t    mpipe [MAP_LAT+1];
    logic [11:0] spipe [RD_LAT+1];
    wexp_t       wq [$];
    int          rq [$];
    int mode = 0, k = 0, cyc = 0, n_req = 0, n_wr = 0, n_rd = 0, n_rd_exp = 0, n_done = 0;
    int first_req = -1, last_req = 0, first_wr = -1, last_wr = 0, done_cyc = 0;
    bit prev_done = 1'b0;

    // Source coordinate the mapper returns for destination pixel idx.
    function automatic void pick_src(input int md, input int idx, output int sx, output int sy);
        sx = idx % W;
        sy = idx / W;
        if (md == 1 && idx < 4) begin
            case (idx)
                0: begin sx = -1; sy = 0; end
                1: begin sx = 8;  sy = 0; end
                2: begin sx = 0;  sy = 4; end
                default: begin sx = 7; sy = 3; end
            endcase
        end else if (md == 2) begin
            if ($urandom_range(0, 7) == 0) begin
                sx = int'($urandom_range(0, 2047));
                sy = int'($urandom_range(0, 2047));
                if (sx > 1023) sx -= 2048;
                if (sy > 1023) sy -= 2048;
            end else begin
                sx = sx + int'($urandom_range(0, 6)) - 3;
                sy = sy + int'($urandom_range(0, 4)) - 2;
            end
        end
    endfunction

    always @(negedge clk) begin : mon
        int sx, sy;
        bit inr;
        map_ent_t nm;
        logic [11:0] nd;
        wexp_t e;
        cyc++;
        if (prev_done) check("busy_after_done", busy, 0);
        prev_done = done;
        nm = '{v: 1'b0, sx: 11'($urandom), sy: 11'($urandom)};
        if (map_req) begin
            check("map_x", map_x, k % W);
            check("map_y", map_y, k / W);
            pick_src(mode, k, sx, sy);
            inr = (sx >= 0) && (sx < W) && (sy >= 0) && (sy < H);
            wq.push_back('{addr: k, data: inr ? src_mem[sy*W + sx] : BG});
            if (inr) begin
                rq.push_back(sy * W + sx);
                n_rd_exp++;
            end
            nm = '{v: 1'b1, sx: sx[10:0], sy: sy[10:0]};
            if (first_req < 0) first_req = cyc;
            last_req = cyc;
            n_req++;
            k++;
        end
        for (int i = MAP_LAT; i > 0; i--) mpipe[i] = mpipe[i-1];
        mpipe[0] = nm;
        map_valid = mpipe[MAP_LAT].v;
        map_sx    = mpipe[MAP_LAT].sx;
        map_sy    = mpipe[MAP_LAT].sy;

        nd = 12'($urandom);
        if (src_rd_en) begin
            n_rd++;
            if (rq.size() == 0) check("rd_unexpected", 1, 0);
            else check("src_rd_addr", src_rd_addr, rq.pop_front());
            if (src_rd_addr < N) nd = src_mem[src_rd_addr];
        end
        for (int i = RD_LAT; i > 0; i--) spipe[i] = spipe[i-1];
        spipe[0] = nd;
        src_rd_data = spipe[RD_LAT];

        if (dst_we) begin
            n_wr++;
            if (first_wr < 0) first_wr = cyc;
            last_wr = cyc;
            if (wq.size() == 0) check("wr_unexpected", 1, 0);
            else begin
                e = wq.pop_front();
                check("dst_addr", dst_addr, e.addr);
                check("dst_data", dst_data, e.data);
            end
        end
        if (done) begin
            n_done++;
            done_cyc = cyc;
        end
    end

    task automatic run_small(input int md, input bit rand_src, input bit do_hold,
                             input bit do_restart, input bit do_reset);
        int t, held;
        bit r1, r2;
        @(posedge clk); #2;
        for (int i = 0; i < N; i++) src_mem[i] = rand_src ? 12'($urandom) : 12'(i);
        mode = md; wq.delete(); rq.delete();
        k = 0; n_req = 0; n_wr = 0; n_rd = 0; n_rd_exp = 0; n_done = 0;
        first_req = -1; first_wr = -1; last_req = 0; last_wr = 0; done_cyc = 0;
        held = 0; r1 = 0; r2 = 0; t = 0;
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        while (n_done == 0 && t < 400) begin
            hold  = 1'b0;
            start = 1'b0;
            if (do_hold && held < 5 && k >= 2 * W + 3) begin
                hold = 1'b1;
                held++;
            end
            if (do_restart && !r1 && k == 5) begin
                start = 1'b1;
                r1 = 1'b1;
            end else if (do_restart && !r2 && n_req == N && n_wr < N - 2) begin
                start = 1'b1;
                r2 = 1'b1;
            end
            if (do_reset && n_wr >= 10) begin
                reset_n = 1'b0;
                #1;
                check("reset_outputs_zero", |{busy, done, map_req, map_x, map_y, src_rd_en,
                      src_rd_addr, dst_we, dst_addr, dst_data}, 0);
                @(posedge clk); #2;
                reset_n = 1'b1;
                repeat (15) @(posedge clk);
                #2;
                check("no_done_after_reset", n_done, 0);
                check("idle_after_reset", busy, 0);
                return;
            end
            @(posedge clk); #2;
            t++;
        end
        hold = 1'b0;
        start = 1'b0;
        check("done_seen", n_done > 0, 1);
        repeat (3) @(posedge clk);
        #2;
        check("write_count", n_wr, N);
        check("req_count", n_req, N);
        check("done_count", n_done, 1);
        check("first_write_latency", first_wr - first_req, LAT);
        check("done_after_last_write", done_cyc - last_wr, 1);
        check("req_span", last_req - first_req + 1, N + held);
        check("read_count", n_rd, n_rd_exp);
        check("wq_empty", wq.size(), 0);
        check("rq_empty", rq.size(), 0);
        check("busy_idle", busy, 0);
    endtask

    // ---------------- full-size engine: identity map, ramp source ----------------
    map_ent_t    b_mpipe [MAP_LAT+1];
    logic [11:0] b_spipe [RD_LAT+1];
    int  b_k = 0, b_cyc = 0, b_nwr = 0, b_ndone = 0, b_bad = 0;
    int  b_first_req = -1, b_last_wr = 0, b_done_cyc = 0;
    bit  b_finished = 1'b0;

    always @(negedge clk) begin : b_mon
        map_ent_t nm;
        logic [11:0] nd;
        b_cyc++;
        nm = '{v: 1'b0, sx: 11'd0, sy: 11'd0};
        if (b_map_req) begin
            if (b_map_x != 9'(b_k % BW) || b_map_y != 8'(b_k / BW)) b_bad++;
            if (b_first_req < 0) b_first_req = b_cyc;
            nm = '{v: 1'b1, sx: 11'(b_k % BW), sy: 11'(b_k / BW)};
            b_k++;
        end
        for (int i = MAP_LAT; i > 0; i--) b_mpipe[i] = b_mpipe[i-1];
        b_mpipe[0] = nm;
        b_map_valid = b_mpipe[MAP_LAT].v;
        b_map_sx    = b_mpipe[MAP_LAT].sx;
        b_map_sy    = b_mpipe[MAP_LAT].sy;
        nd = b_src_rd_en ? b_src_rd_addr[11:0] : 12'($urandom);
        for (int i = RD_LAT; i > 0; i--) b_spipe[i] = b_spipe[i-1];
        b_spipe[0] = nd;
        b_src_rd_data = b_spipe[RD_LAT];
        if (b_dst_we) begin
            if (b_dst_addr != 17'(b_nwr) || b_dst_data != 12'(b_nwr)) b_bad++;
            b_nwr++;
            b_last_wr = b_cyc;
        end
        if (b_done) begin
            b_ndone++;
            b_done_cyc = b_cyc;
        end
    end

    initial begin : big_drv
        int t;
        b_start = 1'b0;
        b_hold  = 1'b0;
        wait (b_reset_n === 1'b1);
        @(posedge clk); #2;
        b_start = 1'b1;
        @(posedge clk); #2;
        b_start = 1'b0;
        t = 0;
        while (b_ndone == 0 && t < 80000) begin
            @(posedge clk);
            t++;
        end
        repeat (3) @(posedge clk);
        #2;
        check("big_done_seen", b_ndone > 0, 1);
        check("big_mismatches", b_bad, 0);
        check("big_write_count", b_nwr, BN);
        check("big_done_count", b_ndone, 1);
        check("big_run_cycles", b_last_wr - b_first_req + 1, BN + LAT);
        check("big_done_after_last_write", b_done_cyc - b_last_wr, 1);
        check("big_busy_idle", b_busy, 0);
        b_finished = 1'b1;
    end

    // ---------------- main sequence ----------------
    initial begin : main
        int t;
        reset_n = 1'b0; b_reset_n = 1'b0; start = 1'b0; hold = 1'b0;
        map_valid = 1'b0; map_sx = '0; map_sy = '0; src_rd_data = '0;
        b_map_valid = 1'b0; b_map_sx = '0; b_map_sy = '0; b_src_rd_data = '0;
        for (int i = 0; i <= MAP_LAT; i++) begin
            mpipe[i]   = '{v: 1'b0, sx: 11'd0, sy: 11'd0};
            b_mpipe[i] = '{v: 1'b0, sx: 11'd0, sy: 11'd0};
        end
        for (int i = 0; i <= RD_LAT; i++) begin
            spipe[i]   = '0;
            b_spipe[i] = '0;
        end
        #1;
        check("reset_state", |{busy, done, map_req, src_rd_en, dst_we, dst_addr, dst_data}, 0);
        repeat (3) @(posedge clk);

        // Start asserted on the same edge that releases reset must be ignored.
        @(posedge clk);
        reset_n   = 1'b1;
        b_reset_n = 1'b1;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("start_at_reset_release_ignored", busy, 0);

        run_small(0, 1'b0, 1'b0, 1'b0, 1'b0);   // identity map, ramp source
        run_small(1, 1'b0, 1'b0, 1'b0, 1'b0);   // boundary coordinates
        run_small(2, 1'b1, 1'b1, 1'b0, 1'b0);   // random map with hold
        run_small(2, 1'b1, 1'b0, 1'b1, 1'b0);   // extra starts in RUN and DRAIN
        run_small(0, 1'b1, 1'b0, 1'b0, 1'b1);   // reset mid-run
        run_small(0, 1'b0, 1'b0, 1'b0, 1'b0);   // clean run after reset
        for (int r = 0; r < 3; r++) run_small(2, 1'b1, 1'b0, 1'b0, 1'b0);

        t = 0;
        while (!b_finished && t < 90000) begin
            @(posedge clk);
            t++;
        end
        check("big_run_finished", b_finished, 1);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/pixel_transform_engine.md
Name: pixel_transform_engine

Overview:
- Downstream execution stage of the top-level rectification FSM. Launched by the one-cycle pixel_transform_start pulse; returns the one-cycle pixel_transform_done pulse.
- Scans every destination pixel in raster order and sends its (x,y) to the fixed-latency homography mapper.
- For each returned source coordinate: fetches the source pixel from the captured frame BRAM, or substitutes BG_COLOR if the coordinate is out of bounds, then writes the result to the destination frame BRAM.

Parameters:
- IMG_W, 320, frame width in pixels.
- IMG_H, 240, frame height in pixels.
- XW, 9, unsigned destination x width.
- YW, 8, unsigned destination y width.
- SW, 11, signed width of mapper source coordinates.
- ADDR_W, 17, linear frame address width.
- PIX_W, 12, pixel width (RGB444).
- MAP_LAT, 4, mapper latency in cycles from map_req to map_valid.
- RD_LAT, 2, source BRAM read latency.
- BG_COLOR, 12'h000, fill value for out-of-bounds pixels.

Ports:
- clk, in, 1, system clock.
- reset_n, in, 1, asynchronous active-low reset.
- start, in, 1, one-cycle launch pulse (pixel_transform_start).
- hold, in, 1, when high, issue no new coordinates; in-flight pixels still complete.
- busy, out, 1, high from launch until done.
- done, out, 1, one-cycle completion pulse (pixel_transform_done).
- map_req, out, 1, coordinate valid to mapper.
- map_x, out, XW, destination x.
- map_y, out, YW, destination y.
- map_valid, in, 1, mapper result valid; exactly MAP_LAT cycles after map_req.
- map_sx, in, SW, signed source x.
- map_sy, in, SW, signed source y.
- src_rd_en, out, 1, source BRAM read enable.
- src_rd_addr, out, ADDR_W, source address.
- src_rd_data, in, PIX_W, source data, RD_LAT cycles after src_rd_en.
- dst_we, out, 1, destination write enable.
- dst_addr, out, ADDR_W, destination address.
- dst_data, out, PIX_W, destination pixel.

Behaviour:
- Reset (asynchronous, any time including mid-operation):
  - State returns to IDLE; counters and all pipeline valid bits clear.
  - All outputs are 0.
  - In-flight pixels are discarded. No done pulse is generated.
- States:
  - IDLE: start moves to RUN and clears x,y. busy=0.
  - RUN: each cycle with hold=0, assert map_req with the current (x,y), then advance x. At x=IMG_W-1, x wraps to 0 and y increments. Issuing (IMG_W-1,IMG_H-1) moves to DRAIN. With hold=1, map_req=0 and x,y are frozen.
  - DRAIN: wait until the in-flight count reaches 0, then go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
  - busy=1 in RUN, DRAIN and DONE.
- Start while not IDLE is ignored. Start and reset_n deassertion on the same edge: the start is ignored.
- Destination address:
  - Computed at issue time as y*IMG_W+x, using an incrementing linear counter, not a multiplier.
  - Carried alongside the pixel in a delay line of depth MAP_LAT.
- Mapper return, stage R, registered, on a cycle with map_valid:
  - in_range = map_sx in 0..IMG_W-1 and map_sy in 0..IMG_H-1, compared as signed. Negative coordinates are out of range.
  - If in_range: src_rd_en=1 and src_rd_addr = map_sy*IMG_W+map_sx, truncated to ADDR_W.
  - If out of range: src_rd_en=0.
- Write stage: the in_range flag and destination address are delayed RD_LAT further. The following cycle asserts dst_we=1, dst_data = in_range ? src_rd_data : BG_COLOR, and dst_addr = the delayed destination address.
- Per-pixel latency from map_req to dst_we is MAP_LAT+RD_LAT+2 cycles. Throughput is 1 pixel/clk when hold=0.
- Write ordering and count:
  - Writes occur in raster order with no gaps except those caused by hold.
  - Exactly IMG_W*IMG_H writes per run; the final write precedes done by 1 cycle.
- In-flight counter:
  - Increments on map_req, decrements on dst_we.
  - When both occur in the same cycle, the count is unchanged.
  - Width is clog2(MAP_LAT+RD_LAT+3).
- map_valid outside the expected issue slots is ignored. The pipeline advances on internal valid bits; map_valid is checked only by assertion.

Decomposition:
- Package pt_pkg holds:
  - the state encoding (IDLE=0, RUN=1, DRAIN=2, DONE=3);
  - default IMG_W, IMG_H and BG_COLOR;
  - the pipeline depth constants derived from MAP_LAT and RD_LAT.
- One sub-module, pt_delay_line: a parameterised width/depth shift register with async active-low clear. It is instantiated for the issue-to-return stage (addr+valid) and the read stage (addr+in_range+valid).

Test Plan:
- IMG_W=8, IMG_H=4, identity mapper, ramp source (pixel = address) -> 32 writes, dst_data = dst_addr, first dst_we 8 cycles after the first map_req, done 1 cycle after write 31, busy low the cycle after done.
- Mapper returns (-1,0), (8,0), (0,4) and (7,3) -> first three pixels written BG_COLOR with src_rd_en=0; the fourth reads address 31.
- hold asserted for 5 cycles mid-row 2 -> map_req gaps of 5, no duplicate or skipped dst_addr, 32 writes total, done still fires once.
- start pulsed again during RUN and DRAIN -> ignored; the write count stays 32 and only one done pulse occurs.
- reset_n low for 1 cycle at write 10 -> all outputs 0 at once, no done; a new start yields a clean 32-write run starting at dst_addr 0.
- Full 320x240 run with hold=0 -> 76800 writes in 76800+MAP_LAT+RD_LAT+2 cycles, then one done pulse.
